// File: rtl/wam_pkg.sv
// wam_pkg: shared defaults, debounce state type and warm-up length for the hit judge
package wam_pkg;
  localparam int WAM_N_CH = 8;
  localparam int WAM_SCORE_W = 8;
  localparam int WAM_WARMUP = 3;
  typedef enum logic {IDLE, FILTER} db_state_t;
endpackage

// File: rtl/wam_db_chan.sv
// wam_db_chan: one switch channel - 2-flop sync, edge detect, debounce FSM, tap pulse
// Ports: clk_19 clock, rst async active-high reset, sw raw switch level,
//        en edge enable (low during warm-up), tap one-cycle accepted-toggle pulse
module wam_db_chan
  import wam_pkg::*;
#(
  parameter int DB_CNT = 4
) (
  input  logic clk_19,
  input  logic rst,
  input  logic sw,
  input  logic en,
  output logic tap
);
  localparam int CW = $clog2(DB_CNT + 1);
  db_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic sw_s1, sw_s2, sw_pre, sw_edge, tap_n;
  always_ff @(posedge clk_19 or posedge rst)
    if (rst) begin
      {sw_s1, sw_s2, sw_pre, tap} <= '0;
      state <= IDLE;
      cnt <= '0;
    end else begin
      {sw_s1, sw_s2, sw_pre} <= {sw, sw_s1, sw_s2};
      state <= state_n;
      cnt <= cnt_n;
      tap <= tap_n;
    end
  // A bounce while filtering returns to IDLE without restarting; only a later edge restarts.
  always_comb begin
    sw_edge = en & (sw_s2 ^ sw_pre);
    state_n = state;
    cnt_n = cnt;
    tap_n = 1'b0;
    if (state == IDLE) begin
      if (sw_edge) begin
        cnt_n = CW'(1);
        state_n = FILTER;
      end
    end else if (cnt >= CW'(DB_CNT)) begin
      cnt_n = '0;
      tap_n = 1'b1;
      state_n = IDLE;
    end else if (sw_edge) begin
      cnt_n = '0;
      state_n = IDLE;
    end else cnt_n = cnt + CW'(1);
  end
endmodule

// File: rtl/wam_hit_judge.sv
// wam_hit_judge: debounced switch taps judged against mole holes into hit/miss pulses with per-hole lockout
// Ports: clk_19 clock, rst async active-high reset, sw raw switches, holes mole-present vector,
//        tap/hit/miss one-cycle pulses per channel.
// Optional WAM_HIT_STAT_EN: adds stat_clr, hit_cnt, miss_cnt saturating statistics (SCORE_W wide).
module wam_hit_judge
  import wam_pkg::*;
#(
  parameter int N_CH = WAM_N_CH,
  parameter int DB_CNT = 4
`ifdef WAM_HIT_STAT_EN
  , parameter int SCORE_W = WAM_SCORE_W
`endif
) (
  input  logic              clk_19,
  input  logic              rst,
  input  logic [N_CH-1:0]   sw,
  input  logic [N_CH-1:0]   holes,
  output logic [N_CH-1:0]   tap,
  output logic [N_CH-1:0]   hit,
  output logic [N_CH-1:0]   miss
`ifdef WAM_HIT_STAT_EN
  , input  logic              stat_clr,
  output logic [SCORE_W-1:0] hit_cnt,
  output logic [SCORE_W-1:0] miss_cnt
`endif
);
  localparam int WW = $clog2(WAM_WARMUP + 1);
  logic [WW-1:0] wu;
  logic en;
  logic [N_CH-1:0] holes_pre, lock;
  // Edges are masked until the synchroniser has flushed the reset-time zeros.
  assign en = wu == WW'(WAM_WARMUP);
  always_ff @(posedge clk_19 or posedge rst)
    if (rst) wu <= '0;
    else wu <= en ? wu : wu + WW'(1);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    wam_db_chan #(.DB_CNT(DB_CNT)) u_ch (
      .clk_19(clk_19),
      .rst(rst),
      .sw(sw[i]),
      .en(en),
      .tap(tap[i])
    );
  end
  // Lock holds for the rest of the mole's appearance once it has been tapped.
  always_ff @(posedge clk_19 or posedge rst)
    if (rst) begin
      holes_pre <= '0;
      hit <= '0;
      miss <= '0;
      lock <= '0;
    end else begin
      holes_pre <= holes;
      hit <= tap & holes_pre & ~lock;
      miss <= tap & ~holes_pre;
      lock <= holes_pre & (lock | tap);
    end
`ifdef WAM_HIT_STAT_EN
  localparam int AW = SCORE_W + $clog2(N_CH + 1);
  localparam logic [AW-1:0] MAX = {{(AW - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
  logic [AW-1:0] hit_sum, miss_sum;
  assign hit_sum = AW'(hit_cnt) + AW'($countones(hit));
  assign miss_sum = AW'(miss_cnt) + AW'($countones(miss));
  always_ff @(posedge clk_19 or posedge rst)
    if (rst) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      hit_cnt <= stat_clr ? '0 : hit_sum > MAX ? MAX[SCORE_W-1:0] : hit_sum[SCORE_W-1:0];
      miss_cnt <= stat_clr ? '0 : miss_sum > MAX ? MAX[SCORE_W-1:0] : miss_sum[SCORE_W-1:0];
    end
`endif
endmodule

// File: tb/tb_wam_hit_judge.sv
// tb_wam_hit_judge: directed and random stimulus checked against a window-based reference model
module tb_wam_hit_judge;
  localparam int N = 8;
  localparam int DB = 4;
  logic clk_19 = 0, rst = 0;
  logic [N-1:0] sw = '0, holes = '0, tap, hit, miss;
  int passed = 0, total = 0;
`ifdef WAM_HIT_STAT_EN
  localparam int SW_W = 2;
  localparam int CMAX = (1 << SW_W) - 1;
  logic stat_clr = 0;
  logic [SW_W-1:0] hit_cnt, miss_cnt;
  int m_hc = 0, m_mc = 0;
  wam_hit_judge #(.N_CH(N), .DB_CNT(DB), .SCORE_W(SW_W)) dut (
    .clk_19(clk_19), .rst(rst), .sw(sw), .holes(holes), .tap(tap), .hit(hit), .miss(miss),
    .stat_clr(stat_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );
`else
  wam_hit_judge #(.N_CH(N), .DB_CNT(DB)) dut (
    .clk_19(clk_19), .rst(rst), .sw(sw), .holes(holes), .tap(tap), .hit(hit), .miss(miss)
  );
`endif
  always #5 clk_19 = ~clk_19;
  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
  endtask
  // Reference model: x(n) = sw sampled at the n-th edge after reset release.
  // A raw change between x(n-3) and x(n-2) is seen at edge n (n>3, after warm-up). If the channel
  // has no open window it opens one due at edge n+DB; a change seen while a window is open kills it,
  // except on the due edge itself, where the tap wins and the change is lost.
  logic [N-1:0] q0 = '0, q1 = '0, q2 = '0, hp = '0, m_tap = '0, m_hit = '0, m_miss = '0, scored = '0;
  logic [N-1:0] nt, nh, nm;
  int pend [N] = '{default: 0};
  int n = 0;
  always @(posedge clk_19) begin
    if (rst) begin
      n = 0;
      {q0, q1, q2, hp, m_tap, m_hit, m_miss, scored} = '0;
      for (int i = 0; i < N; i++) pend[i] = 0;
`ifdef WAM_HIT_STAT_EN
      m_hc = 0;
      m_mc = 0;
`endif
    end else begin
      n++;
      nt = '0;
      for (int i = 0; i < N; i++) begin
        if (pend[i] != 0 && pend[i] == n) begin
          nt[i] = 1'b1;
          pend[i] = 0;
        end else if (n > 3 && q1[i] != q2[i]) pend[i] = (pend[i] != 0) ? 0 : n + DB;
      end
      nh = m_tap & hp & ~scored;
      nm = m_tap & ~hp;
      scored = hp & (scored | m_tap);
`ifdef WAM_HIT_STAT_EN
      m_hc = stat_clr ? 0 : (m_hc + $countones(m_hit) > CMAX ? CMAX : m_hc + $countones(m_hit));
      m_mc = stat_clr ? 0 : (m_mc + $countones(m_miss) > CMAX ? CMAX : m_mc + $countones(m_miss));
`endif
      m_tap = nt;
      m_hit = nh;
      m_miss = nm;
      q2 = q1;
      q1 = q0;
      q0 = sw;
      hp = holes;
    end
  end
  always @(negedge clk_19) begin
    chk("tap", tap, m_tap);
    chk("hit", hit, m_hit);
    chk("miss", miss, m_miss);
`ifdef WAM_HIT_STAT_EN
    chk("hit_cnt", hit_cnt, m_hc);
    chk("miss_cnt", miss_cnt, m_mc);
`endif
  end
  task automatic wait_tap(input int ch, output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk_19);
      if (tap[ch]) begin
        lat = c - 1;
        break;
      end
    end
  endtask
  initial begin
    int lat;
    logic [N-1:0] acc;
    #2 rst = 1;
    sw = 8'hFF;
    repeat (3) @(negedge clk_19);
    #1 rst = 0;
    acc = '0;
    repeat (20) begin
      @(negedge clk_19);
      acc |= tap | hit | miss;
    end
    chk("warmup_quiet", acc, 0);
    #1 holes = 8'h04;
    sw[2] = 1'b0;
    wait_tap(2, lat);
    chk("lat_ch2", lat, 6);
    @(negedge clk_19);
    chk("hit_ch2", hit, 8'h04);
    chk("miss_ch2", miss, 0);
    #1 sw[5] = ~sw[5];
    repeat (2) @(negedge clk_19);
    #1 sw[5] = ~sw[5];
    acc = '0;
    repeat (15) begin
      @(negedge clk_19);
      acc |= tap;
    end
    chk("bounce_no_tap", acc[5], 0);
    #1 sw[5] = ~sw[5];
    wait_tap(5, lat);
    chk("lat_ch5", lat, 6);
    #1 holes = 8'h02;
    repeat (2) @(negedge clk_19);
    #1 sw[1] = ~sw[1];
    wait_tap(1, lat);
    @(negedge clk_19);
    chk("lock_hit1", hit, 8'h02);
    repeat (8) @(negedge clk_19);
    #1 sw[1] = ~sw[1];
    wait_tap(1, lat);
    @(negedge clk_19);
    chk("lock_hit2", hit, 0);
    chk("lock_miss2", miss, 0);
    #1 holes = 8'h00;
    repeat (3) @(negedge clk_19);
    #1 holes = 8'h02;
    repeat (2) @(negedge clk_19);
    #1 sw[1] = ~sw[1];
    wait_tap(1, lat);
    @(negedge clk_19);
    chk("relock_hit", hit, 8'h02);
`ifdef WAM_HIT_STAT_EN
    #1 stat_clr = 1;
    @(negedge clk_19);
    #1 stat_clr = 0;
`endif
    #1 holes = 8'h01;
    sw = sw ^ 8'h81;
    wait_tap(0, lat);
    chk("tap07", tap, 8'h81);
    @(negedge clk_19);
    chk("hit07", hit, 8'h01);
    chk("miss07", miss, 8'h80);
`ifdef WAM_HIT_STAT_EN
    @(negedge clk_19);
    chk("cnt07_hit", hit_cnt, 1);
    chk("cnt07_miss", miss_cnt, 1);
    #1 holes = 8'h00;
    repeat (3) @(negedge clk_19);
    #1 holes = 8'h3E;
    repeat (2) @(negedge clk_19);
    #1 sw = sw ^ 8'h3E;
    wait_tap(1, lat);
    @(negedge clk_19);
    chk("sat_hits", hit, 8'h3E);
    @(negedge clk_19);
    chk("sat_hit_cnt", hit_cnt, 3);
    #1 holes = 8'h40;
    repeat (2) @(negedge clk_19);
    #1 sw[6] = ~sw[6];
    wait_tap(6, lat);
    @(negedge clk_19);
    chk("clr_hit", hit, 8'h40);
    #1 stat_clr = 1;
    @(negedge clk_19);
    chk("clr_hit_cnt", hit_cnt, 0);
    #1 stat_clr = 0;
`endif
    #1 sw[3] = ~sw[3];
    repeat (3) @(negedge clk_19);
    #1 rst = 1;
    @(negedge clk_19);
    #1 rst = 0;
    acc = '0;
    repeat (15) begin
      @(negedge clk_19);
      acc |= tap;
    end
    chk("reset_abort", acc, 0);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_19);
      #1;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(c < 750 ? 7 : 23) == 0) sw[i] = ~sw[i];
        if ($urandom_range(15) == 0) holes[i] = ~holes[i];
      end
      if (c == 900) rst = 1;
      if (c == 903) rst = 0;
`ifdef WAM_HIT_STAT_EN
      stat_clr = $urandom_range(63) == 0;
`endif
    end
    repeat (2) @(negedge clk_19);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
